mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port and the shared
// memory bus.
//   slave  : arbiter view (takes requests, drives acks and the memory bus)
//   master : environment view (requesters plus the memory model)
// i_m_* : instruction port (read-only, 16-bit)
// d_m_* : data port (read/write with byte select)
// q_m_* : shared memory bus
interface mem_arbiter_if;
    logic [19:1] i_m_addr;
    logic [15:0] i_m_data_in;
    logic        i_m_access;
    logic        i_m_ack;

    logic [19:1] d_m_addr;
    logic [15:0] d_m_data_in;
    logic [15:0] d_m_data_out;
    logic        d_m_access;
    logic        d_m_ack;
    logic        d_m_wr_en;
    logic [1:0]  d_m_bytesel;

    logic [19:1] q_m_addr;
    logic [15:0] q_m_data_in;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_ack;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;

    modport slave (
        input  i_m_addr, i_m_access,
        output i_m_data_in, i_m_ack,
        input  d_m_addr, d_m_data_out, d_m_access, d_m_wr_en, d_m_bytesel,
        output d_m_data_in, d_m_ack,
        output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        input  q_m_data_in, q_m_ack
    );

    modport master (
        output i_m_addr, i_m_access,
        input  i_m_data_in, i_m_ack,
        output d_m_addr, d_m_data_out, d_m_access, d_m_wr_en, d_m_bytesel,
        input  d_m_data_in, d_m_ack,
        input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        output q_m_data_in, q_m_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction port and a data port onto a single
// memory bus, one transaction outstanding at a time.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave (i_m_*, d_m_*, q_m_* signal groups)
// Data normally wins, but after STARVE_LIMIT consecutive data grants made
// while the instruction port waits, the instruction port gets one grant.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [1:0] state_q, state_d;
    logic [2:0] starve_q, starve_d;
    logic       grant_d, grant_i;

    // Grant decision, only acted upon in IDLE.
    always_comb begin
        grant_d = bus.d_m_access & (~bus.i_m_access | (starve_q < LIMIT));
        grant_i = ~grant_d & bus.i_m_access;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                    // Only count data grants that actually make the
                    // instruction port wait.
                    if (bus.i_m_access)
                        starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 3'd1;
                    else
                        starve_d = 3'd0;
                end else if (grant_i) begin
                    state_d  = SERVE_I;
                    starve_d = 3'd0;
                end
            end
            // Ack ends the transaction; dropping access aborts it.
            SERVE_I: if (!bus.i_m_access || bus.q_m_ack) state_d = IDLE;
            SERVE_D: if (!bus.d_m_access || bus.q_m_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Memory-side mux. Outputs depend only on the registered state and the
    // granted port, so reset clears them without waiting for a clock edge.
    always_comb begin
        bus.q_m_addr     = '0;
        bus.q_m_data_out = '0;
        bus.q_m_access   = 1'b0;
        bus.q_m_wr_en    = 1'b0;
        bus.q_m_bytesel  = 2'b00;
        bus.i_m_ack      = 1'b0;
        bus.d_m_ack      = 1'b0;
        case (state_q)
            SERVE_I: begin
                bus.q_m_addr    = bus.i_m_addr;
                bus.q_m_access  = bus.i_m_access & ~bus.q_m_ack;
                bus.q_m_bytesel = 2'b11;
                bus.i_m_ack     = bus.q_m_ack;
            end
            SERVE_D: begin
                bus.q_m_addr     = bus.d_m_addr;
                bus.q_m_data_out = bus.d_m_data_out;
                bus.q_m_access   = bus.d_m_access & ~bus.q_m_ack;
                bus.q_m_wr_en    = bus.d_m_wr_en;
                bus.q_m_bytesel  = bus.d_m_bytesel;
                bus.d_m_ack      = bus.q_m_ack;
            end
            default: ;
        endcase
    end

    // Read data goes to both ports; only the acked port samples it.
    assign bus.i_m_data_in = bus.q_m_data_in;
    assign bus.d_m_data_in = bus.q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_d;
        logic [18:0] addr;
        logic        wr;
        logic [1:0]  bs;
        logic [15:0] dout;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected grant derived from what the requester is presenting now.
    task automatic push_i();
        exp_t e;
        e.is_d = 1'b0; e.addr = bus.i_m_addr; e.wr = 1'b0; e.bs = 2'b11; e.dout = 16'h0000;
        sb.push_back(e);
    endtask

    task automatic push_d();
        exp_t e;
        e.is_d = 1'b1; e.addr = bus.d_m_addr; e.wr = bus.d_m_wr_en;
        e.bs = bus.d_m_bytesel; e.dout = bus.d_m_data_out;
        sb.push_back(e);
    endtask

    // Called one cycle after the grant decision: bus must show the grant.
    task automatic check_grant(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_access"}, {31'd0, bus.q_m_access}, 32'd1);
        chk({tag, "_addr"},   {13'd0, bus.q_m_addr}, {13'd0, e.addr});
        chk({tag, "_wr"},     {31'd0, bus.q_m_wr_en}, {31'd0, e.wr});
        chk({tag, "_bs"},     {30'd0, bus.q_m_bytesel}, {30'd0, e.bs});
        chk({tag, "_dout"},   {16'd0, bus.q_m_data_out}, {16'd0, e.dout});
        chk({tag, "_noack"},  {30'd0, bus.i_m_ack, bus.d_m_ack}, 32'd0);
    endtask

    // Pulse q_m_ack for one cycle and check routing, then the bubble.
    task automatic complete(input string tag, input logic is_d, input logic [15:0] data, input logic drop);
        bus.q_m_ack = 1'b1;
        bus.q_m_data_in = data;
        #1;
        chk({tag, "_iack"},   {31'd0, bus.i_m_ack}, {31'd0, ~is_d});
        chk({tag, "_dack"},   {31'd0, bus.d_m_ack}, {31'd0, is_d});
        chk({tag, "_acc_ack"}, {31'd0, bus.q_m_access}, 32'd0);
        chk({tag, "_idata"},  {16'd0, bus.i_m_data_in}, {16'd0, data});
        chk({tag, "_ddata"},  {16'd0, bus.d_m_data_in}, {16'd0, data});
        tick();
        bus.q_m_ack = 1'b0;
        if (drop) begin
            if (is_d) bus.d_m_access = 1'b0;
            else      bus.i_m_access = 1'b0;
        end
        #1;
        chk({tag, "_bubble"}, {31'd0, bus.q_m_access}, 32'd0);
        chk({tag, "_bub_addr"}, {13'd0, bus.q_m_addr}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.i_m_addr = '0; bus.i_m_access = 1'b0;
        bus.d_m_addr = '0; bus.d_m_data_out = '0; bus.d_m_access = 1'b0;
        bus.d_m_wr_en = 1'b0; bus.d_m_bytesel = 2'b00;
        bus.q_m_data_in = '0; bus.q_m_ack = 1'b0;

        #12;
        chk("rst_access", {31'd0, bus.q_m_access}, 32'd0);
        chk("rst_acks",   {30'd0, bus.i_m_ack, bus.d_m_ack}, 32'd0);
        chk("rst_addr",   {13'd0, bus.q_m_addr}, 32'd0);
        #5 reset_n = 1'b1;
        tick();

        // Data read alone.
        bus.d_m_access = 1'b1; bus.d_m_addr = 19'h00010; bus.d_m_bytesel = 2'b01;
        bus.d_m_wr_en = 1'b0; bus.d_m_data_out = 16'h0000;
        #1;
        chk("rd_idle_acc",  {31'd0, bus.q_m_access}, 32'd0);
        chk("rd_idle_addr", {13'd0, bus.q_m_addr}, 32'd0);
        push_d();
        tick();
        check_grant("rd");
        complete("rd", 1'b1, 16'h1234, 1'b1);

        // Simultaneous requests: data first, then instruction after bubble.
        bus.i_m_access = 1'b1; bus.i_m_addr = 19'h00400;
        bus.d_m_access = 1'b1; bus.d_m_addr = 19'h00020; bus.d_m_bytesel = 2'b11;
        bus.d_m_data_out = 16'hAAAA;
        push_d();
        push_i();
        tick();
        check_grant("sim_d");
        complete("sim_d", 1'b1, 16'h5678, 1'b1);
        tick();
        check_grant("sim_i");
        complete("sim_i", 1'b0, 16'h9ABC, 1'b1);

        // Starvation: both held; 4 data grants, 1 instruction, repeat.
        bus.i_m_access = 1'b1; bus.i_m_addr = 19'h01000;
        bus.d_m_access = 1'b1; bus.d_m_addr = 19'h02000; bus.d_m_bytesel = 2'b01;
        bus.d_m_wr_en = 1'b1; bus.d_m_data_out = 16'hCAFE;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) push_i();
            else                  push_d();
            tick();
            check_grant($sformatf("stv%0d", k));
            complete($sformatf("stv%0d", k), !(k == 4 || k == 9), 16'(k), 1'b0);
        end
        bus.i_m_access = 1'b0; bus.d_m_access = 1'b0;
        tick();

        // Data write to top address, held for a wait state.
        bus.d_m_access = 1'b1; bus.d_m_addr = 19'h7FFFF; bus.d_m_wr_en = 1'b1;
        bus.d_m_data_out = 16'hBEEF; bus.d_m_bytesel = 2'b10;
        push_d();
        tick();
        check_grant("wr");
        tick();
        chk("wr_hold_acc",  {31'd0, bus.q_m_access}, 32'd1);
        chk("wr_hold_dout", {16'd0, bus.q_m_data_out}, 32'h0000BEEF);
        chk("wr_hold_iack", {31'd0, bus.i_m_ack}, 32'd0);
        complete("wr", 1'b1, 16'h0000, 1'b1);
        bus.d_m_wr_en = 1'b0;

        // Abort: instruction port drops access before ack.
        bus.i_m_access = 1'b1; bus.i_m_addr = 19'h00123;
        push_i();
        tick();
        check_grant("abort");
        bus.i_m_access = 1'b0;
        #1;
        chk("abort_acc", {31'd0, bus.q_m_access}, 32'd0);
        tick();
        chk("abort_idle_addr", {13'd0, bus.q_m_addr}, 32'd0);

        // Async reset during SERVE_I.
        bus.i_m_access = 1'b1; bus.i_m_addr = 19'h00055;
        push_i();
        tick();
        check_grant("ar");
        reset_n = 1'b0;
        bus.q_m_ack = 1'b1;
        #1;
        chk("ar_acc",  {31'd0, bus.q_m_access}, 32'd0);
        chk("ar_iack", {31'd0, bus.i_m_ack}, 32'd0);
        bus.q_m_ack = 1'b0;
        #1 reset_n = 1'b1;
        #1;
        chk("ar_rel_acc", {31'd0, bus.q_m_access}, 32'd0);
        push_i();
        tick();
        check_grant("ar_regrant");
        complete("ar", 1'b0, 16'h4321, 1'b1);

        // Stray ack in IDLE is ignored.
        bus.q_m_ack = 1'b1;
        #1;
        chk("stray_acks", {30'd0, bus.i_m_ack, bus.d_m_ack}, 32'd0);
        tick();
        chk("stray_acks2", {30'd0, bus.i_m_ack, bus.d_m_ack}, 32'd0);
        chk("stray_acc",   {31'd0, bus.q_m_access}, 32'd0);
        bus.q_m_ack = 1'b0;
        bus.d_m_access = 1'b1; bus.d_m_addr = 19'h00777; bus.d_m_bytesel = 2'b01;
        bus.d_m_data_out = 16'h0000;
        push_d();
        tick();
        check_grant("stray_after");
        complete("stray_after", 1'b1, 16'h1111, 1'b1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
